// File: rtl/mem_wb_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage_buf
// Purpose  : Elastic two-entry MEM->WB pipeline stage. It replaces a plain
//            always-advancing MEM/WB register with a main register (which
//            drives every output) and a skid register. That way a stall from
//            write-back never reaches in_ready combinationally. Also produces
//            the final write-back data, the register-file write enable and a
//            bypass hint for forwarding.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_W        width of alu_result / mem_data / wb_data
//   RD_W          width of the destination register index
//   RD0_READONLY  1 = never write register index 0
// Ports
//   clk, reset           rising-edge clock, async active-high reset
//   flush                synchronous kill of all buffered entries
//   in_valid/in_ready    upstream handshake (in_ready is a flop output)
//   in_alu_result, in_mem_data, in_rd, in_reg_write, in_mem_to_reg
//                        MEM-stage payload
//   out_valid/out_ready  downstream handshake (head entry)
//   wb_rd, wb_data, wb_we
//                        write-back view of the head entry
//   byp_valid            head will write a register (ignores out_ready)
//   occupancy            number of buffered entries, 0..2
// ============================================================================
module mem_wb_stage_buf #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned RD_W         = 2,
    parameter int unsigned RD0_READONLY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we,
    output logic              byp_valid,
    output logic [1:0]        occupancy
);

    localparam logic c_RD0_RO = (RD0_READONLY != 0);

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] mem_data;
        logic [RD_W-1:0]   rd;
        logic              reg_write;
        logic              mem_to_reg;
    } entry_t;

    // State encoding is {main_valid, skid_valid}, so the valid bits are
    // read directly from the state register. 2'b01 is never entered.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    state_t r_state;
    state_t w_state_next;

    entry_t r_main;
    entry_t r_skid;
    entry_t w_in_entry;

    logic w_main_valid;
    logic w_skid_valid;
    logic w_acc;
    logic w_deq;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid_in;
    logic w_rd_blocked;
    logic w_writes_reg;

    assign w_main_valid = r_state[1];
    assign w_skid_valid = r_state[0];

    assign w_in_entry.alu_result = in_alu_result;
    assign w_in_entry.mem_data   = in_mem_data;
    assign w_in_entry.rd         = in_rd;
    assign w_in_entry.reg_write  = in_reg_write;
    assign w_in_entry.mem_to_reg = in_mem_to_reg;

    // in_ready comes straight from a flop, so downstream stalls cannot
    // form a combinational path back to the MEM stage.
    assign in_ready  = ~w_skid_valid;
    assign out_valid = w_main_valid;

    assign w_acc = in_valid & in_ready;
    assign w_deq = out_valid & out_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and load controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid_in   = 1'b0;

        if (flush) begin
            // Kill everything. Any offer in this cycle is dropped, even
            // when in_ready is high.
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_load_main_in = 1'b1;
                        w_state_next   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_deq) begin
                        w_load_main_in = 1'b1;
                    end else if (w_acc) begin
                        w_load_skid_in = 1'b1;
                        w_state_next   = ST_FULL;
                    end else if (w_deq) begin
                        w_state_next   = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a dequeue can happen.
                    // The skid entry moves up, which keeps FIFO order.
                    if (w_deq) begin
                        w_load_main_skid = 1'b1;
                        w_state_next     = ST_ONE;
                    end
                end
                default: begin
                    w_state_next = ST_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Payload registers: load only when a valid entry is written into them
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main <= '0;
        end else if (w_load_main_in) begin
            r_main <= w_in_entry;
        end else if (w_load_main_skid) begin
            r_main <= r_skid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skid <= '0;
        end else if (w_load_skid_in) begin
            r_skid <= w_in_entry;
        end
    end

    // ------------------------------------------------------------------
    // Write-back view (main register only)
    // ------------------------------------------------------------------
    assign w_rd_blocked = c_RD0_RO && (r_main.rd == '0);
    assign w_writes_reg = w_main_valid & r_main.reg_write & ~w_rd_blocked;

    assign wb_rd     = r_main.rd;
    assign wb_data   = r_main.mem_to_reg ? r_main.mem_data : r_main.alu_result;
    assign wb_we     = w_writes_reg & out_ready;
    assign byp_valid = w_writes_reg;
    assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

`ifndef SYNTHESIS
    // The skid register may only hold an entry while main also holds one.
    a_skid_implies_main : assert property (
        @(posedge clk) disable iff (reset) (w_skid_valid |-> w_main_valid)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage_buf
// Purpose  : Self-checking bench for mem_wb_stage_buf. A scoreboard queue
//            holds the entries the stage should contain. Entries are pushed
//            when an offer is accepted and popped when the head is consumed.
//            Two instances share all inputs: one with RD0_READONLY = 1 and
//            one with the default of 0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage_buf;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_alu_result;
    logic [7:0] in_mem_data;
    logic [1:0] in_rd;
    logic       in_reg_write;
    logic       in_mem_to_reg;
    logic       out_ready;

    logic       in_ready, out_valid, wb_we, byp_valid;
    logic [1:0] wb_rd, occupancy;
    logic [7:0] wb_data;

    logic       in_ready_b, out_valid_b, wb_we_b, byp_valid_b;
    logic [1:0] wb_rd_b, occupancy_b;
    logic [7:0] wb_data_b;

    mem_wb_stage_buf #(.DATA_W(8), .RD_W(2), .RD0_READONLY(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_we(wb_we),
        .byp_valid(byp_valid), .occupancy(occupancy)
    );

    mem_wb_stage_buf #(.DATA_W(8), .RD_W(2), .RD0_READONLY(0)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .wb_rd(wb_rd_b), .wb_data(wb_data_b), .wb_we(wb_we_b),
        .byp_valid(byp_valid_b), .occupancy(occupancy_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] rd;
        logic [7:0] data;
        logic       rw;
    } ent_t;

    ent_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [1:0] rd,
                         input logic [7:0] alu, input logic [7:0] mem,
                         input logic ordy, input logic fl);
        in_valid      = v;
        in_reg_write  = rw;
        in_mem_to_reg = m2r;
        in_rd         = rd;
        in_alu_result = alu;
        in_mem_data   = mem;
        out_ready     = ordy;
        flush         = fl;
    endtask

    // Called just after a falling edge once inputs are set. Compares the
    // outputs against the model, advances the model, then steps one cycle.
    task automatic tick();
        int   n;
        logic acc, deq;
        ent_t e;
        #1;
        n = q.size();
        check("occupancy", 32'(occupancy), 32'(n));
        check("in_ready", 32'(in_ready), 32'(n < 2));
        check("out_valid", 32'(out_valid), 32'(n > 0));
        check("occupancy_b", 32'(occupancy_b), 32'(n));
        if (n > 0) begin
            check("wb_rd", 32'(wb_rd), 32'(q[0].rd));
            check("wb_data", 32'(wb_data), 32'(q[0].data));
            check("wb_we", 32'(wb_we), 32'(out_ready & q[0].rw & (q[0].rd != 2'd0)));
            check("byp_valid", 32'(byp_valid), 32'(q[0].rw & (q[0].rd != 2'd0)));
            check("wb_we_b", 32'(wb_we_b), 32'(out_ready & q[0].rw));
            check("byp_valid_b", 32'(byp_valid_b), 32'(q[0].rw));
        end else begin
            check("wb_we_idle", 32'(wb_we), 32'd0);
            check("byp_valid_idle", 32'(byp_valid), 32'd0);
        end
        if (flush) begin
            q.delete();
        end else begin
            acc = in_valid && (n < 2);
            deq = (n > 0) && out_ready;
            if (deq) void'(q.pop_front());
            if (acc) begin
                e.rd   = in_rd;
                e.data = in_mem_to_reg ? in_mem_data : in_alu_result;
                e.rw   = in_reg_write;
                q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 0);
        @(negedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_occupancy", 32'(occupancy), 32'd0);
        check("reset_wb_data", 32'(wb_data), 32'd0);
        check("reset_wb_rd", 32'(wb_rd), 32'd0);
        check("reset_wb_we", 32'(wb_we), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Fill to FULL with rd 1 and 2, then reset asynchronously between edges.
        drive(1, 1, 0, 2'd1, 8'h5A, 8'h00, 0, 0); tick();
        drive(1, 1, 0, 2'd2, 8'h6B, 8'h00, 0, 0); tick();
        drive(0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 0); tick();
        #2 reset = 1'b1;
        #1;
        check("async_reset_out_valid", 32'(out_valid), 32'd0);
        check("async_reset_in_ready", 32'(in_ready), 32'd1);
        check("async_reset_occupancy", 32'(occupancy), 32'd0);
        check("async_reset_wb_data", 32'(wb_data), 32'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Streaming with out_ready high: 1-cycle latency and full throughput.
        drive(1, 1, 0, 2'd1, 8'h11, 8'hEE, 1, 0); tick();
        drive(1, 1, 0, 2'd2, 8'h22, 8'hEE, 1, 0); tick();
        drive(1, 1, 0, 2'd3, 8'h33, 8'hEE, 1, 0); tick();
        drive(0, 0, 0, 2'd0, 8'h00, 8'h00, 1, 0); tick();
        tick();

        // Backpressure: A, B fill the stage, C waits, then everything drains.
        drive(1, 1, 1, 2'd1, 8'h01, 8'hA5, 0, 0); tick();
        drive(1, 1, 1, 2'd2, 8'h02, 8'hB6, 0, 0); tick();
        drive(1, 1, 0, 2'd3, 8'hC7, 8'h00, 0, 0); tick();
        tick();
        check("bp_head_is_A", 32'(wb_data), 32'hA5);
        out_ready = 1'b1; tick();
        tick();
        in_valid = 1'b0; tick();
        tick();
        tick();

        // Flush while FULL with an offer pending; head still writes this cycle.
        drive(1, 1, 0, 2'd1, 8'h44, 8'h00, 0, 0); tick();
        drive(1, 1, 0, 2'd2, 8'h55, 8'h00, 0, 0); tick();
        drive(1, 1, 0, 2'd3, 8'h66, 8'h00, 1, 1); tick();
        drive(0, 0, 0, 2'd0, 8'h00, 8'h00, 1, 0); tick();
        check("post_flush_occupancy", 32'(occupancy), 32'd0);

        // Read-only register 0 suppresses the write but still dequeues.
        drive(1, 1, 0, 2'd0, 8'h77, 8'h00, 1, 0); tick();
        drive(1, 1, 0, 2'd3, 8'h88, 8'h00, 1, 0); tick();
        drive(0, 0, 0, 2'd0, 8'h00, 8'h00, 1, 0); tick();
        tick();

        // Randomised valid/ready with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
            tick();
        end
        drive(0, 0, 0, 2'd0, 8'h00, 8'h00, 1, 0);
        tick();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
